// File: rtl/fifo_pkg.sv
// Shared constants and state encoding for the fifo upstream push controller.
package fifo_pkg;

   localparam int unsigned BUS_SIZE_DEF   = 5;
   localparam int unsigned SKID_DEPTH_DEF = 4;

   localparam logic ST_RUN   = 1'b0;
   localparam logic ST_STALL = 1'b1;

   typedef enum logic {
      S_RUN   = ST_RUN,
      S_STALL = ST_STALL
   } push_state_e;

endpackage

// File: rtl/skid_buf.sv
// Circular skid buffer: power-of-two depth, wrapping pointers, occupancy count.
module skid_buf
   import fifo_pkg::*;
#(
   parameter int unsigned WIDTH = BUS_SIZE_DEF,
   parameter int unsigned DEPTH = SKID_DEPTH_DEF,
   localparam int unsigned PW   = $clog2(DEPTH),
   localparam int unsigned CW   = PW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en_i,
   input  logic             rd_en_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q, count_d;

   always_comb begin
      count_d = count_q;
      case ({wr_en_i, rd_en_i})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en_i) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (rd_en_i) rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_d;
      end
   end

   // Storage is not reset; stale entries are unreachable once the pointers clear.
   always_ff @(posedge clk) begin
      if (wr_en_i) mem_q[wr_ptr_q] <= din_i;
   end

   assign dout_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/fifo_push_ctrl.sv
// Upstream flow control for the fifo: skid-buffers a valid/ready stream and
// pushes into the fifo, holding off while the fifo signals pause until continua.
module fifo_push_ctrl
   import fifo_pkg::*;
#(
   parameter int unsigned BUS_SIZE   = BUS_SIZE_DEF,
   parameter int unsigned SKID_DEPTH = SKID_DEPTH_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   input  logic [BUS_SIZE-1:0] in_data,
   output logic                in_ready,
   input  logic                pause,
   input  logic                continua,
   output logic                push,
   output logic [BUS_SIZE-1:0] data_out,
   output logic                stalled
);

   localparam int unsigned CW = $clog2(SKID_DEPTH) + 1;

   push_state_e         state_q, state_d;
   logic                push_q;
   logic [BUS_SIZE-1:0] data_q;
   logic                stalled_q;

   logic [CW-1:0]       count;
   logic [BUS_SIZE-1:0] head;
   logic                accept;
   logic                drain;

   assign in_ready = (count < CW'(SKID_DEPTH));
   assign accept   = in_valid & in_ready & ~reset;
   // Only drain in RUN with pause low; the edge that enters STALL pushes nothing.
   assign drain    = (state_q == S_RUN) & (count != '0) & ~pause & ~reset;

   skid_buf #(
      .WIDTH (BUS_SIZE),
      .DEPTH (SKID_DEPTH)
   ) u_skid (
      .clk     (clk),
      .reset   (reset),
      .wr_en_i (accept),
      .rd_en_i (drain),
      .din_i   (in_data),
      .dout_o  (head),
      .count_o (count)
   );

   // pause dominates continua when the fifo reports both.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RUN:   if (pause) state_d = S_STALL;
         S_STALL: if (continua && !pause) state_d = S_RUN;
         default: state_d = S_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_RUN;
         push_q    <= 1'b0;
         data_q    <= '0;
         stalled_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         push_q    <= drain;
         stalled_q <= (state_d == S_STALL);
         if (drain) data_q <= head;
      end
   end

   assign push     = push_q;
   assign data_out = data_q;
   assign stalled  = stalled_q;

endmodule

// File: tb/tb_fifo_push_ctrl.sv
// Self-checking bench for fifo_push_ctrl against a queue-based reference model.
module tb_fifo_push_ctrl;

   localparam int W = 5;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic [W-1:0] in_data = '0;
   logic         pause = 1'b0;
   logic         continua = 1'b0;
   logic         in_ready;
   logic         push;
   logic [W-1:0] data_out;
   logic         stalled;

   int checks = 0;
   int errors = 0;

   // Reference model: skid contents as a queue, plus stall flag and output regs.
   logic [W-1:0] m_q [$];
   bit           m_stall = 1'b0;
   bit           m_push  = 1'b0;
   logic [W-1:0] m_data  = '0;
   bit           m_acc   = 1'b0;
   logic [W-1:0] pushed [$];
   int           next_w;

   fifo_push_ctrl #(.BUS_SIZE(W), .SKID_DEPTH(D)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .pause    (pause),
      .continua (continua),
      .push     (push),
      .data_out (data_out),
      .stalled  (stalled)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] exp_vec();
      return {m_push, m_data, m_stall, (m_q.size() < D)};
   endfunction

   task automatic cycle(input bit v, input logic [W-1:0] d, input bit p,
                        input bit c, input bit r);
      bit drn;
      in_valid = v; in_data = d; pause = p; continua = c; reset = r;
      @(posedge clk);
      if (r) begin
         m_q.delete(); m_stall = 0; m_push = 0; m_data = '0; m_acc = 0;
      end else begin
         m_acc  = v && (m_q.size() < D);
         drn    = !m_stall && (m_q.size() > 0) && !p;
         m_push = drn;
         if (drn) m_data = m_q.pop_front();
         if (m_acc) m_q.push_back(d);
         m_stall = m_stall ? !(c && !p) : p;
      end
      #1;
      if (push === 1'b1) pushed.push_back(data_out);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         cycle(1, W'(7), 0, 0, 1);
         checks++;
         if ({push, data_out, stalled, in_ready} !== 8'b0_00000_0_1) begin
            errors++;
            $display("FAIL reset cyc%0d: got %b want 00000001", i,
                     {push, data_out, stalled, in_ready});
         end
      end
      cycle(0, '0, 0, 0, 0);
   endtask

   task automatic test_stream();
      bit           ep;
      logic [W-1:0] ed;
      pushed.delete();
      for (int i = 0; i < 8; i++) begin
         cycle(i < 5, W'(i + 1), 0, 0, 0);
         ep = (i >= 1) && (i <= 5);
         ed = ep ? W'(i) : ((i > 5) ? W'(5) : W'(0));
         checks++;
         if ({push, data_out} !== {ep, ed}) begin
            errors++;
            $display("FAIL stream cyc%0d: push/data got %b/%0d want %b/%0d",
                     i, push, data_out, ep, ed);
         end
      end
      checks++;
      if (pushed.size() != 5) begin
         errors++;
         $display("FAIL stream_count: got %0d pushes want 5", pushed.size());
      end
   endtask

   task automatic test_pause();
      bit p = 0;
      pushed.delete();
      next_w = 1;
      for (int i = 0; i < 12; i++) begin
         cycle(next_w <= 8, W'(next_w), p, 0, 0);
         if (m_acc) next_w++;
         checks++;
         if ({push, data_out, stalled, in_ready} !== exp_vec()) begin
            errors++;
            $display("FAIL pause cyc%0d: got %b want %b", i,
                     {push, data_out, stalled, in_ready}, exp_vec());
         end
         if (pushed.size() >= 2) p = 1;
      end
      checks++;
      if (pushed.size() != 2 || stalled !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL pause_end: pushes=%0d stalled=%b in_ready=%b want 2/1/0",
                  pushed.size(), stalled, in_ready);
      end
   endtask

   task automatic test_resume();
      pushed.delete();
      for (int i = 0; i < 3; i++) begin
         cycle(next_w <= 8, W'(next_w), 0, 0, 0);
         if (m_acc) next_w++;
         checks++;
         if (push !== 1'b0 || stalled !== 1'b1) begin
            errors++;
            $display("FAIL resume_hold cyc%0d: push=%b stalled=%b want 0/1",
                     i, push, stalled);
         end
      end
      for (int i = 0; i < 10; i++) begin
         cycle(next_w <= 8, W'(next_w), 0, 1, 0);
         if (m_acc) next_w++;
         checks++;
         if ({push, data_out, stalled, in_ready} !== exp_vec()) begin
            errors++;
            $display("FAIL resume cyc%0d: got %b want %b", i,
                     {push, data_out, stalled, in_ready}, exp_vec());
         end
      end
      checks++;
      if (pushed.size() != 6) begin
         errors++;
         $display("FAIL resume_count: got %0d pushes want 6", pushed.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (pushed[i] !== W'(i + 3)) begin
               errors++;
               $display("FAIL resume_order[%0d]: got %0d want %0d", i, pushed[i], i + 3);
            end
         end
      end
      checks++;
      if (stalled !== 1'b0) begin
         errors++;
         $display("FAIL resume_stalled: got %b want 0", stalled);
      end
   endtask

   task automatic test_conflict();
      cycle(1, W'(9), 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cycle(0, '0, 1, 1, 0);
         checks++;
         if (push !== 1'b0 || stalled !== 1'b1) begin
            errors++;
            $display("FAIL conflict cyc%0d: push=%b stalled=%b want 0/1",
                     i, push, stalled);
         end
      end
      for (int i = 0; i < 5; i++) begin
         cycle(0, '0, 0, 1, 0);
         checks++;
         if ({push, data_out, stalled, in_ready} !== exp_vec()) begin
            errors++;
            $display("FAIL conflict_release cyc%0d: got %b want %b", i,
                     {push, data_out, stalled, in_ready}, exp_vec());
         end
      end
   endtask

   task automatic test_midop_reset();
      cycle(0, '0, 1, 0, 0);
      for (int i = 0; i < 3; i++) cycle(1, W'(10 + i), 1, 0, 0);
      checks++;
      if (stalled !== 1'b1 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL midop_pre: stalled=%b in_ready=%b want 1/1", stalled, in_ready);
      end
      cycle(1, W'(21), 0, 1, 1);
      checks++;
      if ({push, data_out, stalled, in_ready} !== 8'b0_00000_0_1) begin
         errors++;
         $display("FAIL midop_reset: got %b want 00000001",
                  {push, data_out, stalled, in_ready});
      end
      pushed.delete();
      cycle(1, W'(5'h1F), 0, 0, 0);
      for (int i = 0; i < 5; i++) cycle(0, '0, 0, 0, 0);
      checks++;
      if (pushed.size() != 1 || pushed[0] !== 5'h1F) begin
         errors++;
         $display("FAIL midop_single: pushes=%0d first=%0h want 1/1f",
                  pushed.size(), (pushed.size() > 0) ? pushed[0] : 5'h0);
      end
   endtask

   task automatic test_random();
      bit v, p, c;
      for (int i = 0; i < 400; i++) begin
         v = ($urandom % 4) != 0;
         p = ($urandom % 4) == 0;
         c = ($urandom % 3) == 0;
         cycle(v, W'($urandom), p, c, 0);
         checks++;
         if ({push, data_out, stalled, in_ready} !== exp_vec()) begin
            errors++;
            $display("FAIL random cyc%0d: got %b want %b", i,
                     {push, data_out, stalled, in_ready}, exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_pause();
      test_resume();
      test_conflict();
      test_midop_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
